// File: rtl/ctrl_pkg.sv
// ctrl_pkg - opcode/funct encodings, ALU classes, cause codes, FSM state and control bundle
// Rev 1.0
`default_nettype none

package ctrl_pkg;

    localparam logic [5:0] OP_RTYPE    = 6'd0;
    localparam logic [5:0] OP_REGIMM   = 6'd1;
    localparam logic [5:0] OP_J        = 6'd2;
    localparam logic [5:0] OP_JAL      = 6'd3;
    localparam logic [5:0] OP_BEQ      = 6'd4;
    localparam logic [5:0] OP_BNE      = 6'd5;
    localparam logic [5:0] OP_BLEZ     = 6'd6;
    localparam logic [5:0] OP_BGTZ     = 6'd7;
    localparam logic [5:0] OP_ADDI     = 6'd8;
    localparam logic [5:0] OP_ADDIU    = 6'd9;
    localparam logic [5:0] OP_SLTI     = 6'd10;
    localparam logic [5:0] OP_SLTIU    = 6'd11;
    localparam logic [5:0] OP_ANDI     = 6'd12;
    localparam logic [5:0] OP_ORI      = 6'd13;
    localparam logic [5:0] OP_XORI     = 6'd14;
    localparam logic [5:0] OP_LUI      = 6'd15;
    localparam logic [5:0] OP_COP0     = 6'd16;
    localparam logic [5:0] OP_SPECIAL2 = 6'd28;
    localparam logic [5:0] OP_LB       = 6'd32;
    localparam logic [5:0] OP_LH       = 6'd33;
    localparam logic [5:0] OP_LW       = 6'd35;
    localparam logic [5:0] OP_LBU      = 6'd36;
    localparam logic [5:0] OP_LHU      = 6'd37;
    localparam logic [5:0] OP_SB       = 6'd40;
    localparam logic [5:0] OP_SH       = 6'd41;
    localparam logic [5:0] OP_SW       = 6'd43;

    localparam logic [5:0] F_SLL     = 6'd0;
    localparam logic [5:0] F_SRL     = 6'd2;
    localparam logic [5:0] F_SRA     = 6'd3;
    localparam logic [5:0] F_SLLV    = 6'd4;
    localparam logic [5:0] F_SRLV    = 6'd6;
    localparam logic [5:0] F_SRAV    = 6'd7;
    localparam logic [5:0] F_JR      = 6'd8;
    localparam logic [5:0] F_JALR    = 6'd9;
    localparam logic [5:0] F_SYSCALL = 6'd12;
    localparam logic [5:0] F_BREAK   = 6'd13;
    localparam logic [5:0] F_MFHI    = 6'd16;
    localparam logic [5:0] F_MTHI    = 6'd17;
    localparam logic [5:0] F_MFLO    = 6'd18;
    localparam logic [5:0] F_MTLO    = 6'd19;
    localparam logic [5:0] F_MULT    = 6'd24;
    localparam logic [5:0] F_MULTU   = 6'd25;
    localparam logic [5:0] F_DIV     = 6'd26;
    localparam logic [5:0] F_DIVU    = 6'd27;
    localparam logic [5:0] F_ADD     = 6'd32;
    localparam logic [5:0] F_ADDU    = 6'd33;
    localparam logic [5:0] F_SUB     = 6'd34;
    localparam logic [5:0] F_SUBU    = 6'd35;
    localparam logic [5:0] F_AND     = 6'd36;
    localparam logic [5:0] F_OR      = 6'd37;
    localparam logic [5:0] F_XOR     = 6'd38;
    localparam logic [5:0] F_NOR     = 6'd39;
    localparam logic [5:0] F_SLT     = 6'd42;
    localparam logic [5:0] F_SLTU    = 6'd43;

    localparam logic [4:0] ALU_ADD    = 5'b00000;
    localparam logic [4:0] ALU_RTYPE  = 5'b00010;
    localparam logic [4:0] ALU_BRANCH = 5'b00011;
    localparam logic [4:0] ALU_AND    = 5'b00100;
    localparam logic [4:0] ALU_OR     = 5'b00101;
    localparam logic [4:0] ALU_XOR    = 5'b00110;
    localparam logic [4:0] ALU_SLT    = 5'b00111;
    localparam logic [4:0] ALU_SLTU   = 5'b01000;
    localparam logic [4:0] ALU_LUI    = 5'b01001;
    localparam logic [4:0] ALU_MUL    = 5'b01010;

    localparam logic [4:0] EXC_SYS = 5'd8;
    localparam logic [4:0] EXC_BP  = 5'd9;
    localparam logic [4:0] EXC_RI  = 5'd10;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MDU_WAIT = 2'd1,
        EXC_WAIT = 2'd2
    } state_e;

    // Byte-enable class; the stage expands it to the configured bus width.
    typedef enum logic [1:0] {
        BE_NONE = 2'd0,
        BE_BYTE = 2'd1,
        BE_HALF = 2'd2,
        BE_ALL  = 2'd3
    } be_sel_e;

    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic       mem_to_reg;
        logic       branch;
        logic       alu_src;
        logic       reg_dst;
        logic       jump;
        logic       jr;
        logic       link;
        logic       arith_u;
        logic       cop;
        be_sel_e    be_sel;
        logic [4:0] alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = '0;

endpackage

`default_nettype wire

// File: rtl/ctrl_decode_comb.sv
// ctrl_decode_comb - pure decode table: instruction word to control bundle, MDU and exception flags
// Rev 1.0
`default_nettype none

module ctrl_decode_comb
    import ctrl_pkg::*;
#(
    parameter int MDU_EN = 1
) (
    input  logic [31:0] instr_i,
    output ctrl_t       ctrl_o,
    output logic        is_mdu_o,
    output logic [1:0]  mdu_op_o,
    output logic        exc_o,
    output logic [4:0]  exc_code_o
);

    logic [5:0] op;
    logic [5:0] funct;
    logic       ri;
    logic       sys;
    logic       bp;
    logic       unused_instr_bits;

    assign op                = instr_i[31:26];
    assign funct             = instr_i[5:0];
    assign unused_instr_bits = ^instr_i[25:6];

    always_comb begin
        ctrl_o   = CTRL_NONE;
        is_mdu_o = 1'b0;
        ri       = 1'b0;
        sys      = 1'b0;
        bp       = 1'b0;
        case (op)
            OP_RTYPE: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.reg_dst   = 1'b1;
                ctrl_o.alu_op    = ALU_RTYPE;
                ctrl_o.be_sel    = BE_ALL;
                case (funct)
                    F_JR: begin
                        ctrl_o.reg_write = 1'b0;
                        ctrl_o.jr        = 1'b1;
                        ctrl_o.be_sel    = BE_NONE;
                    end
                    F_JALR: begin
                        ctrl_o.jr   = 1'b1;
                        ctrl_o.link = 1'b1;
                    end
                    F_SYSCALL: begin
                        ctrl_o.reg_write = 1'b0;
                        sys              = 1'b1;
                    end
                    F_BREAK: begin
                        ctrl_o.reg_write = 1'b0;
                        bp               = 1'b1;
                    end
                    F_MULT, F_MULTU, F_DIV, F_DIVU: begin
                        ctrl_o.reg_write = 1'b0;
                        if (MDU_EN != 0) begin
                            is_mdu_o = 1'b1;
                        end else begin
                            ri = 1'b1;
                        end
                    end
                    F_SLL, F_SRL, F_SRA, F_SLLV, F_SRLV, F_SRAV,
                    F_MFHI, F_MTHI, F_MFLO, F_MTLO,
                    F_ADD, F_ADDU, F_SUB, F_SUBU,
                    F_AND, F_OR, F_XOR, F_NOR, F_SLT, F_SLTU: ;
                    default: ri = 1'b1;
                endcase
            end
            OP_ADDI, OP_ADDIU: begin
                ctrl_o.alu_op    = ALU_ADD;
                ctrl_o.alu_src   = 1'b1;
                ctrl_o.reg_write = 1'b1;
            end
            OP_LW, OP_LB, OP_LH, OP_LBU, OP_LHU: begin
                ctrl_o.mem_to_reg = 1'b1;
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.alu_src    = 1'b1;
                ctrl_o.alu_op     = ALU_ADD;
                ctrl_o.arith_u    = (op == OP_LBU) || (op == OP_LHU);
                if (op == OP_LW) begin
                    ctrl_o.be_sel = BE_ALL;
                end else if (op == OP_LB || op == OP_LBU) begin
                    ctrl_o.be_sel = BE_BYTE;
                end else begin
                    ctrl_o.be_sel = BE_HALF;
                end
            end
            OP_SW, OP_SB, OP_SH: begin
                ctrl_o.mem_write = 1'b1;
                ctrl_o.alu_src   = 1'b1;
                ctrl_o.alu_op    = ALU_ADD;
                if (op == OP_SW) begin
                    ctrl_o.be_sel = BE_ALL;
                end else if (op == OP_SB) begin
                    ctrl_o.be_sel = BE_BYTE;
                end else begin
                    ctrl_o.be_sel = BE_HALF;
                end
            end
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_REGIMM: begin
                ctrl_o.alu_op = ALU_BRANCH;
                ctrl_o.branch = 1'b1;
            end
            OP_ANDI, OP_ORI, OP_XORI: begin
                ctrl_o.alu_src   = 1'b1;
                ctrl_o.reg_write = 1'b1;
                ctrl_o.arith_u   = 1'b1;
                if (op == OP_ANDI) begin
                    ctrl_o.alu_op = ALU_AND;
                end else if (op == OP_ORI) begin
                    ctrl_o.alu_op = ALU_OR;
                end else begin
                    ctrl_o.alu_op = ALU_XOR;
                end
            end
            OP_SLTI, OP_SLTIU, OP_LUI: begin
                ctrl_o.alu_src   = 1'b1;
                ctrl_o.reg_write = 1'b1;
                if (op == OP_SLTI) begin
                    ctrl_o.alu_op = ALU_SLT;
                end else if (op == OP_SLTIU) begin
                    ctrl_o.alu_op = ALU_SLTU;
                end else begin
                    ctrl_o.alu_op = ALU_LUI;
                end
            end
            OP_SPECIAL2: begin
                ctrl_o.alu_op    = ALU_MUL;
                ctrl_o.reg_dst   = 1'b1;
                ctrl_o.reg_write = 1'b1;
            end
            OP_COP0: begin
                ctrl_o.cop       = 1'b1;
                ctrl_o.reg_write = 1'b1;
            end
            OP_J: begin
                ctrl_o.jump = 1'b1;
            end
            OP_JAL: begin
                ctrl_o.jump      = 1'b1;
                ctrl_o.link      = 1'b1;
                ctrl_o.reg_write = 1'b1;
            end
            default: ri = 1'b1;
        endcase
    end

    // mult/multu/div/divu occupy funct 24..27, so the low bits are the MDU op.
    assign mdu_op_o   = funct[1:0];
    assign exc_o      = ri | sys | bp;
    assign exc_code_o = sys ? EXC_SYS : (bp ? EXC_BP : EXC_RI);

endmodule

`default_nettype wire

// File: rtl/ctrl_decode_stage.sv
// ctrl_decode_stage - registered MIPS decode/control stage with MDU start/done and CP0 exception sequencing
// Rev 1.0
`default_nettype none

module ctrl_decode_stage
    import ctrl_pkg::*;
#(
    parameter int BE_W    = 4,
    parameter int ALUOP_W = 5,
    parameter int EXC_W   = 5,
    parameter int MDU_EN  = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [31:0]        instr_D,
    input  logic               valid_D,
    input  logic               stall_i,
    input  logic               flush_i,
    input  logic               mdu_done,
    input  logic               exc_ack,
    output logic               RegWrite_E,
    output logic               MemWrite_E,
    output logic               MemtoReg_E,
    output logic               Branch_E,
    output logic               AluSrc_E,
    output logic               RegDst_E,
    output logic               Jump_E,
    output logic               Jr_E,
    output logic               Link_E,
    output logic               ArithU_E,
    output logic               Cop_E,
    output logic [BE_W-1:0]    ByteEn_E,
    output logic [ALUOP_W-1:0] alu_opcode_E,
    output logic               mdu_start,
    output logic [1:0]         mdu_op,
    output logic               stall_o,
    output logic               exc_req,
    output logic [EXC_W-1:0]   exc_code
);

    ctrl_t              dec_ctrl;
    logic               dec_is_mdu;
    logic [1:0]         dec_mdu_op;
    logic               dec_exc;
    logic [4:0]         dec_exc_code;

    state_e             state_q;
    logic [10:0]        flags_q;
    logic [10:0]        flags_d;
    logic [BE_W-1:0]    byte_en_q;
    logic [BE_W-1:0]    byte_en_d;
    logic [ALUOP_W-1:0] alu_q;
    logic [ALUOP_W-1:0] alu_d;
    logic               mdu_start_q;
    logic [1:0]         mdu_op_q;
    logic               exc_req_q;
    logic [EXC_W-1:0]   exc_code_q;
    logic               replay_block_q;
    logic               issue_ok;
    ctrl_t              e_ctrl_d;

    ctrl_decode_comb #(
        .MDU_EN (MDU_EN)
    ) u_decode (
        .instr_i    (instr_D),
        .ctrl_o     (dec_ctrl),
        .is_mdu_o   (dec_is_mdu),
        .mdu_op_o   (dec_mdu_op),
        .exc_o      (dec_exc),
        .exc_code_o (dec_exc_code)
    );

    assign stall_o = (state_q != IDLE);

    // After a wait completes, the front end still holds the finished instruction
    // in decode until IF/ID advances; it must not be issued a second time.
    assign issue_ok = valid_D && !flush_i && !stall_i && !stall_o && !replay_block_q;

    always_comb begin
        e_ctrl_d = CTRL_NONE;
        if (issue_ok && !dec_exc && !dec_is_mdu) begin
            e_ctrl_d = dec_ctrl;
        end
    end

    always_comb begin
        flags_d   = {e_ctrl_d.reg_write, e_ctrl_d.mem_write, e_ctrl_d.mem_to_reg,
                     e_ctrl_d.branch, e_ctrl_d.alu_src, e_ctrl_d.reg_dst,
                     e_ctrl_d.jump, e_ctrl_d.jr, e_ctrl_d.link,
                     e_ctrl_d.arith_u, e_ctrl_d.cop};
        alu_d     = ALUOP_W'(e_ctrl_d.alu_op);
        byte_en_d = '0;
        case (e_ctrl_d.be_sel)
            BE_BYTE: byte_en_d[0]   = 1'b1;
            BE_HALF: byte_en_d[1:0] = 2'b11;
            BE_ALL:  byte_en_d      = '1;
            default: byte_en_d      = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            flags_q        <= '0;
            byte_en_q      <= '0;
            alu_q          <= '0;
            mdu_start_q    <= 1'b0;
            mdu_op_q       <= 2'b00;
            exc_req_q      <= 1'b0;
            exc_code_q     <= '0;
            replay_block_q <= 1'b0;
        end else begin
            flags_q     <= flags_d;
            byte_en_q   <= byte_en_d;
            alu_q       <= alu_d;
            mdu_start_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    replay_block_q <= replay_block_q && stall_i && !flush_i;
                    if (issue_ok && dec_exc) begin
                        exc_req_q  <= 1'b1;
                        exc_code_q <= EXC_W'(dec_exc_code);
                        state_q    <= EXC_WAIT;
                    end else if (issue_ok && dec_is_mdu) begin
                        mdu_start_q <= 1'b1;
                        mdu_op_q    <= dec_mdu_op;
                        state_q     <= MDU_WAIT;
                    end
                end
                MDU_WAIT: begin
                    // A done coincident with the start pulse belongs to no operation of ours.
                    if (mdu_done && !mdu_start_q) begin
                        state_q        <= IDLE;
                        replay_block_q <= 1'b1;
                    end
                end
                EXC_WAIT: begin
                    if (exc_ack) begin
                        exc_req_q      <= 1'b0;
                        state_q        <= IDLE;
                        replay_block_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign {RegWrite_E, MemWrite_E, MemtoReg_E, Branch_E, AluSrc_E, RegDst_E,
            Jump_E, Jr_E, Link_E, ArithU_E, Cop_E} = flags_q;
    assign ByteEn_E     = byte_en_q;
    assign alu_opcode_E = alu_q;
    assign mdu_start    = mdu_start_q;
    assign mdu_op       = mdu_op_q;
    assign exc_req      = exc_req_q;
    assign exc_code     = exc_code_q;

endmodule

`default_nettype wire

// File: tb/tb_ctrl_decode_stage.sv
// tb_ctrl_decode_stage - table-driven scoreboard bench plus hand sequences for MDU, exception and reset corners
// Rev 1.0
`default_nettype none

module tb_ctrl_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr_D = 32'h8E080004;
    logic        valid_D = 1'b1;
    logic        stall_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        mdu_done = 1'b0;
    logic        exc_ack = 1'b0;

    logic RegWrite_E, MemWrite_E, MemtoReg_E, Branch_E, AluSrc_E, RegDst_E;
    logic Jump_E, Jr_E, Link_E, ArithU_E, Cop_E;
    logic [3:0] ByteEn_E;
    logic [4:0] alu_opcode_E;
    logic       mdu_start;
    logic [1:0] mdu_op;
    logic       stall_o;
    logic       exc_req;
    logic [4:0] exc_code;

    logic [31:0] instr8 = 32'h0;
    logic        valid8 = 1'b0;
    logic        ack8 = 1'b0;
    logic        zero8 = 1'b0;
    logic RegWrite8, MemWrite8, MemtoReg8, Branch8, AluSrc8, RegDst8;
    logic Jump8, Jr8, Link8, ArithU8, Cop8;
    logic [7:0] ByteEn8;
    logic [4:0] alu8;
    logic       mdu_start8;
    logic [1:0] mdu_op8;
    logic       stall8;
    logic       exc_req8;
    logic [4:0] exc_code8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ctrl_decode_stage dut (
        .clk(clk), .rst_n(rst_n), .instr_D(instr_D), .valid_D(valid_D),
        .stall_i(stall_i), .flush_i(flush_i), .mdu_done(mdu_done), .exc_ack(exc_ack),
        .RegWrite_E(RegWrite_E), .MemWrite_E(MemWrite_E), .MemtoReg_E(MemtoReg_E),
        .Branch_E(Branch_E), .AluSrc_E(AluSrc_E), .RegDst_E(RegDst_E), .Jump_E(Jump_E),
        .Jr_E(Jr_E), .Link_E(Link_E), .ArithU_E(ArithU_E), .Cop_E(Cop_E),
        .ByteEn_E(ByteEn_E), .alu_opcode_E(alu_opcode_E), .mdu_start(mdu_start),
        .mdu_op(mdu_op), .stall_o(stall_o), .exc_req(exc_req), .exc_code(exc_code)
    );

    ctrl_decode_stage #(.BE_W(8), .ALUOP_W(5), .EXC_W(5), .MDU_EN(0)) dut8 (
        .clk(clk), .rst_n(rst_n), .instr_D(instr8), .valid_D(valid8),
        .stall_i(zero8), .flush_i(zero8), .mdu_done(zero8), .exc_ack(ack8),
        .RegWrite_E(RegWrite8), .MemWrite_E(MemWrite8), .MemtoReg_E(MemtoReg8),
        .Branch_E(Branch8), .AluSrc_E(AluSrc8), .RegDst_E(RegDst8), .Jump_E(Jump8),
        .Jr_E(Jr8), .Link_E(Link8), .ArithU_E(ArithU8), .Cop_E(Cop8),
        .ByteEn_E(ByteEn8), .alu_opcode_E(alu8), .mdu_start(mdu_start8),
        .mdu_op(mdu_op8), .stall_o(stall8), .exc_req(exc_req8), .exc_code(exc_code8)
    );

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic        valid;
        logic        stall;
        logic        flush;
        logic [22:0] exp;
    } vec_t;

    vec_t        vecs[$];
    logic [22:0] sb_exp[$];
    string       sb_name[$];

    // {E flags, ByteEn, alu, mdu_start, stall_o, exc_req}
    function automatic logic [22:0] obs();
        return {RegWrite_E, MemWrite_E, MemtoReg_E, Branch_E, AluSrc_E, RegDst_E,
                Jump_E, Jr_E, Link_E, ArithU_E, Cop_E, ByteEn_E, alu_opcode_E,
                mdu_start, stall_o, exc_req};
    endfunction

    function automatic logic [22:0] ctl(input logic rw, input logic mw, input logic mr,
                                        input logic br, input logic as, input logic rd,
                                        input logic j, input logic jr, input logic lk,
                                        input logic au, input logic cp,
                                        input logic [3:0] be, input logic [4:0] alu);
        return {rw, mw, mr, br, as, rd, j, jr, lk, au, cp, be, alu, 3'b000};
    endfunction

    task automatic add_vec(input string name, input logic [31:0] ins, input logic v,
                           input logic s, input logic f, input logic [22:0] e);
        vec_t t;
        t.name = name; t.instr = ins; t.valid = v; t.stall = s; t.flush = f; t.exp = e;
        vecs.push_back(t);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_exc(input string name, input logic [31:0] ins,
                           input logic [4:0] code, input logic with_flush);
        logic [22:0] o;
        @(negedge clk);
        instr_D = ins; valid_D = 1'b1;
        @(posedge clk); #1;
        check({name, " raise"}, {exc_req, exc_code, stall_o, RegWrite_E, mdu_start},
              {1'b1, code, 1'b1, 1'b0, 1'b0});
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            exc_ack = (i == 3);
            flush_i = with_flush && (i == 1);
            @(posedge clk); #1;
            o = obs();
            if (i < 3)
                check({name, " hold"}, {exc_req, exc_code, stall_o, o[22:3]},
                      {1'b1, code, 1'b1, 20'h0});
            else
                check({name, " release"}, {exc_req, stall_o}, 2'b00);
        end
        @(negedge clk);
        exc_ack = 1'b0; flush_i = 1'b0;
        @(posedge clk); #1;
        check({name, " no re-raise"}, {exc_req, stall_o}, 2'b00);
        @(negedge clk);
        valid_D = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [22:0] o;
        int          stall_cnt;

        add_vec("lw",        32'h8E080004, 1, 0, 0, ctl(1,0,1,0,1,0,0,0,0,0,0,4'hF,5'd0));
        add_vec("add",       32'h012A4020, 1, 0, 0, ctl(1,0,0,0,0,1,0,0,0,0,0,4'hF,5'd2));
        add_vec("jr",        32'h03E00008, 1, 0, 0, ctl(0,0,0,0,0,1,0,1,0,0,0,4'h0,5'd2));
        add_vec("jalr",      32'h0320F809, 1, 0, 0, ctl(1,0,0,0,0,1,0,1,1,0,0,4'hF,5'd2));
        add_vec("addi",      32'h21080001, 1, 0, 0, ctl(1,0,0,0,1,0,0,0,0,0,0,4'h0,5'd0));
        add_vec("addiu",     32'h25080001, 1, 0, 0, ctl(1,0,0,0,1,0,0,0,0,0,0,4'h0,5'd0));
        add_vec("lbu",       32'h91080000, 1, 0, 0, ctl(1,0,1,0,1,0,0,0,0,1,0,4'h1,5'd0));
        add_vec("lh",        32'h85080000, 1, 0, 0, ctl(1,0,1,0,1,0,0,0,0,0,0,4'h3,5'd0));
        add_vec("sw",        32'hAD080000, 1, 0, 0, ctl(0,1,0,0,1,0,0,0,0,0,0,4'hF,5'd0));
        add_vec("sh",        32'hA5080000, 1, 0, 0, ctl(0,1,0,0,1,0,0,0,0,0,0,4'h3,5'd0));
        add_vec("beq",       32'h11090003, 1, 0, 0, ctl(0,0,0,1,0,0,0,0,0,0,0,4'h0,5'd3));
        add_vec("bgez",      32'h05210004, 1, 0, 0, ctl(0,0,0,1,0,0,0,0,0,0,0,4'h0,5'd3));
        add_vec("ori",       32'h3508FFFF, 1, 0, 0, ctl(1,0,0,0,1,0,0,0,0,1,0,4'h0,5'd5));
        add_vec("xori",      32'h3908FFFF, 1, 0, 0, ctl(1,0,0,0,1,0,0,0,0,1,0,4'h0,5'd6));
        add_vec("slti",      32'h29080005, 1, 0, 0, ctl(1,0,0,0,1,0,0,0,0,0,0,4'h0,5'd7));
        add_vec("sltiu",     32'h2D080005, 1, 0, 0, ctl(1,0,0,0,1,0,0,0,0,0,0,4'h0,5'd8));
        add_vec("lui",       32'h3C081234, 1, 0, 0, ctl(1,0,0,0,1,0,0,0,0,0,0,4'h0,5'd9));
        add_vec("mul",       32'h712A4002, 1, 0, 0, ctl(1,0,0,0,0,1,0,0,0,0,0,4'h0,5'd10));
        add_vec("mfc0",      32'h40086000, 1, 0, 0, ctl(1,0,0,0,0,0,0,0,0,0,1,4'h0,5'd0));
        add_vec("j",         32'h08000010, 1, 0, 0, ctl(0,0,0,0,0,0,1,0,0,0,0,4'h0,5'd0));
        add_vec("jal",       32'h0C000010, 1, 0, 0, ctl(1,0,0,0,0,0,1,0,1,0,0,4'h0,5'd0));
        add_vec("valid0",    32'h8E080004, 0, 0, 0, 23'h0);
        add_vec("addi f+s",  32'h21080001, 1, 1, 1, 23'h0);
        add_vec("addi stall",32'h21080001, 1, 1, 0, 23'h0);
        add_vec("addi flush",32'h21080001, 1, 0, 1, 23'h0);
        add_vec("add again", 32'h012A4020, 1, 0, 0, ctl(1,0,0,0,0,1,0,0,0,0,0,4'hF,5'd2));

        // reset state: decode input is live but reset holds everything low
        repeat (2) @(posedge clk);
        #1;
        check("reset outputs", {9'h0, obs()}, 32'h0);
        check("reset exc_code", {27'h0, exc_code}, 32'h0);
        check("reset dut8 ByteEn", {24'h0, ByteEn8}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // table vectors through the scoreboard
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            instr_D = vecs[i].instr; valid_D = vecs[i].valid;
            stall_i = vecs[i].stall; flush_i = vecs[i].flush;
            sb_exp.push_back(vecs[i].exp);
            sb_name.push_back(vecs[i].name);
            @(posedge clk); #1;
            check(sb_name.pop_front(), {9'h0, obs()}, {9'h0, sb_exp.pop_front()});
        end
        @(negedge clk);
        valid_D = 1'b0; stall_i = 1'b0; flush_i = 1'b0;

        // flushed or stalled MDU/exception instructions must not launch
        @(negedge clk);
        instr_D = 32'h0000000C; valid_D = 1'b1; flush_i = 1'b1;
        @(posedge clk); #1;
        check("flushed syscall", {exc_req, stall_o}, 2'b00);
        @(negedge clk);
        instr_D = 32'h012A001A; flush_i = 1'b0; stall_i = 1'b1;
        @(posedge clk); #1;
        check("stalled div", {mdu_start, stall_o}, 2'b00);
        @(negedge clk);
        stall_i = 1'b0; valid_D = 1'b0;

        // div: start pulse, early done ignored, flush ignored, 5 stall cycles
        @(negedge clk);
        instr_D = 32'h012A001A; valid_D = 1'b1;
        @(posedge clk); #1;
        o = obs();
        check("div start", {mdu_start, mdu_op, stall_o}, 4'b1101);
        check("div E bubble", {12'h0, o[22:3]}, 32'h0);
        stall_cnt = stall_o ? 1 : 0;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            mdu_done = (i == 1) || (i == 5);
            flush_i  = (i == 3);
            @(posedge clk); #1;
            o = obs();
            check("div wait bubble", {o[22:2], o[0]}, 32'h0);
            if (stall_o) stall_cnt++;
        end
        check("div stall cycles", stall_cnt, 5);
        @(negedge clk);
        mdu_done = 1'b0; flush_i = 1'b0;
        @(posedge clk); #1;
        check("div no reissue", {mdu_start, stall_o}, 2'b00);
        @(negedge clk);
        valid_D = 1'b0;

        run_exc("syscall",   32'h0000000C, 5'd8,  1'b1);
        run_exc("break",     32'h0000000D, 5'd9,  1'b0);
        run_exc("undef op",  32'hFC000000, 5'd10, 1'b0);
        run_exc("bad funct", 32'h012A4001, 5'd10, 1'b0);

        // 64-bit bus variant with MDU disabled
        @(negedge clk);
        instr8 = 32'hA1080000; valid8 = 1'b1;
        @(posedge clk); #1;
        check("sb BE_W=8", {MemWrite8, ByteEn8}, {1'b1, 8'h01});
        @(negedge clk);
        instr8 = 32'hAD080000;
        @(posedge clk); #1;
        check("sw BE_W=8", {23'h0, ByteEn8}, 32'hFF);
        @(negedge clk);
        instr8 = 32'h012A0018;
        @(posedge clk); #1;
        check("mult MDU_EN=0", {exc_req8, exc_code8, mdu_start8, stall8}, {1'b1, 5'd10, 1'b0, 1'b1});
        @(negedge clk);
        ack8 = 1'b1;
        @(posedge clk); #1;
        check("mult RI ack", {exc_req8, stall8}, 2'b00);
        @(negedge clk);
        ack8 = 1'b0; valid8 = 1'b0;

        // asynchronous reset in the middle of MDU_WAIT
        @(negedge clk);
        instr_D = 32'h012A001B; valid_D = 1'b1;
        @(posedge clk); #1;
        check("divu start", {mdu_start, mdu_op, stall_o}, 4'b1111);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("async reset mid-MDU", {9'h0, obs()}, 32'h0);
        check("async reset exc", {exc_req, exc_code}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1; instr_D = 32'h012A4020;
        @(posedge clk); #1;
        check("IDLE after reset", {9'h0, obs()}, {9'h0, ctl(1,0,0,0,0,1,0,0,0,0,0,4'hF,5'd2)});
        @(negedge clk);
        valid_D = 1'b0;
        @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ctrl_decode_stage.md
Name: ctrl_decode_stage

Overview:
- Registered decode and control stage sitting between the IF/ID and ID/EX boundaries of the pipelined MIPS core.
- Decodes opcode/funct into the execute-stage control bundle and registers it.
- Sequences multi-cycle MDU operations (mult/multu/div/divu) with a start/done handshake.
- Raises precise decode-time exceptions (RI, Sys, Bp) to CP0 with a req/ack handshake, stalling the front end while either is pending.

Parameters:
- BE_W, 4, byte-enable width of the data bus; 8 selects the 64-bit bus variant.
- ALUOP_W, 5, width of alu_opcode_E.
- EXC_W, 5, width of exc_code.
- MDU_EN, 1, 1 = mult/div sequencing enabled; 0 = those functs decode as RI.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- instr_D  in  32  instruction in decode.
- valid_D  in  1  instr_D is a real instruction (0 = bubble).
- stall_i  in  1  hazard-unit load-use stall; insert bubble into E.
- flush_i  in  1  branch/exception flush; insert bubble into E.
- mdu_done  in  1  MDU result written to HI/LO.
- exc_ack  in  1  CP0 has taken the exception.
- RegWrite_E, MemWrite_E, MemtoReg_E, Branch_E, AluSrc_E, RegDst_E, Jump_E, Jr_E, Link_E, ArithU_E, Cop_E  out  1 each  registered controls.
- ByteEn_E  out  BE_W  registered byte enables.
- alu_opcode_E  out  ALUOP_W  registered ALU class code.
- mdu_start  out  1  one-cycle MDU start pulse.
- mdu_op  out  2  00 mult, 01 multu, 10 div, 11 divu; valid with mdu_start.
- stall_o  out  1  freeze PC and IF/ID.
- exc_req  out  1  exception request to CP0.
- exc_code  out  EXC_W  cause code: 8 Sys, 9 Bp, 10 RI.

Behaviour:
- Reset (async assert, sync deassert):
  - All E outputs 0, ByteEn_E 0.
  - mdu_start, stall_o and exc_req 0; exc_code 0.
  - FSM goes to IDLE.
- Decode table (combinational, then registered):
  - R-type (op 0): alu 00010, RegDst 1, RegWrite 1, ByteEn all-ones.
  - jr (funct 8): RegWrite 0, Jr 1, ByteEn 0.
  - jalr (funct 9): Jr 1, Link 1, RegWrite 1.
  - syscall (12) and break (13): RegWrite 0; raise the exception.
  - mult, multu, div, divu (funct 24–27): RegWrite 0, MDU sequencing.
  - addi/addiu (8/9): alu 00000, AluSrc 1, RegWrite 1.
  - Loads lw/lb/lh/lbu/lhu (35/32/33/36/37): MemtoReg 1, RegWrite 1, ByteEn = all-ones / 1 / 2'b11 zero-extended; ArithU 1 for lbu and lhu.
  - Stores sw/sb/sh (43/40/41): MemWrite 1, AluSrc 1, same byte-enable mapping as loads.
  - Branches beq/bne/blez/bgtz/REGIMM (4/5/6/7/1): alu 00011, Branch 1.
  - andi/ori/xori (12/13/14): alu 00100/00101/00110, ArithU 1.
  - slti 00111, sltiu 01000, lui 01001: AluSrc 1, RegWrite 1.
  - mul (op 28): alu 01010, RegDst 1, RegWrite 1.
  - COP0 (op 16): Cop 1, RegWrite 1.
  - j (2): Jump 1. jal (3): Jump 1, Link 1, RegWrite 1.
  - Any other opcode or unlisted funct: RI.
- Bubble: all E controls and ByteEn_E forced to 0.
- E-register update precedence, each cycle: flush_i > (stall_i or stall_o) > decode.
  - A bubble is loaded whenever any of these is active, or when valid_D = 0.
- FSM states:
  - IDLE:
    - Decoded valid exception, not flushed, not stalled: load a bubble into E (no architectural side effect), set exc_req = 1 and exc_code next cycle, go to EXC_WAIT.
    - Decoded MDU op, not flushed, not stalled: pulse mdu_start for exactly one cycle with mdu_op, load a bubble into E, go to MDU_WAIT.
  - MDU_WAIT:
    - stall_o = 1.
    - On mdu_done, go to IDLE; stall_o drops the same cycle, combinationally from the state.
    - flush_i does not abort the MDU operation.
    - mdu_done arriving in the same cycle as the start pulse is ignored.
  - EXC_WAIT:
    - stall_o = 1; exc_req and exc_code held stable until exc_ack.
    - On exc_ack: exc_req cleared next cycle, go to IDLE.
    - flush_i in this state is ignored.
- stall_o is high in MDU_WAIT and EXC_WAIT, low in IDLE.
- Reset asserted mid-MDU or mid-exception returns to IDLE immediately; the in-flight request is dropped.

Decomposition:
- Shared package ctrl_pkg holds:
  - opcode and funct localparams;
  - ALU class codes;
  - EXC_SYS = 8, EXC_BP = 9, EXC_RI = 10;
  - the FSM state typedef {IDLE, MDU_WAIT, EXC_WAIT};
  - a packed struct for the control bundle.
- Sub-module ctrl_decode_comb: the pure decode table (instr → bundle, is_mdu, exc flags). The sequencer wraps it with the registers and FSM.

Test Plan:
- lw $t0,4($s0) (0x8E080004), valid_D = 1 → next cycle MemtoReg_E = 1, RegWrite_E = 1, AluSrc_E = 1, ByteEn_E = 4'b1111, alu_opcode_E = 0.
- div (funct 26), then mdu_done after 5 cycles:
  - mdu_start high for exactly 1 cycle with mdu_op = 10;
  - stall_o high for 5 cycles;
  - E bubble throughout.
- syscall (0x0000000C):
  - exc_req = 1 and exc_code = 8 next cycle, held for 3 cycles until exc_ack;
  - RegWrite_E = 0;
  - stall_o drops the cycle after ack.
- Undefined opcode 0x3F → exc_code = 10. With MDU_EN = 0, mult → exc_code = 10.
- sb with BE_W = 8 → ByteEn_E = 8'h01. jr → ByteEn_E = 0, Jr_E = 1, RegWrite_E = 0.
- flush_i and stall_i asserted together with a valid addi → E bubble.
- rst_n pulsed low during MDU_WAIT → all outputs 0 asynchronously and state IDLE.
